// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port among NREQ writeback
//   requesters (ALU, LSU, MUL/DIV). Each cycle one requester is picked
//   round-robin. The winning write is registered into a one-deep output
//   stage, and that stage drives the regfile write pins directly. The stage
//   is never back-pressured, so one write per cycle is sustained.
//
// Parameters
//   NREQ  number of writeback requesters (2..8)
//   AW    register address width
//   DW    register data width
//
// Ports
//   clk         clock, all state updates on posedge
//   rst_n       asynchronous active-low reset
//   req_valid   [NREQ]     requester i has a write pending
//   req_rd      [NREQ*AW]  dest reg of requester i in [i*AW +: AW]
//   req_wdata   [NREQ*DW]  write data of requester i in [i*DW +: DW]
//   req_ready   [NREQ]     combinational one-hot grant
//   hold        suppress new grants (debug halt); output stage still drains
//   rf_we       regfile write enable (never set for x0)
//   rf_rd       regfile write address
//   rf_wdata    regfile write data
//   pend_valid  in-flight write to a nonzero reg (same as rf_we)
//   pend_rd     dest of the in-flight write (same as rf_rd)
//   last_gnt    index of the most recently granted requester
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 hold,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_rd,
  output logic [DW-1:0]        rf_wdata,
  output logic                 pend_valid,
  output logic [AW-1:0]        pend_rd,
  output logic [2:0]           last_gnt
);

  // Requester indices always fit in 3 bits because NREQ <= 8.
  localparam int PW = 3;

  // Round-robin successor of a granted index.
  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] g);
    if (int'(g) == NREQ - 1) return '0;
    else                     return g + PW'(1);
  endfunction

  // x0 is hardwired zero: a write targeting it is consumed but never enabled.
  function automatic logic rd_writes(input logic [AW-1:0] rd);
    return |rd;
  endfunction

  logic [PW-1:0]   ptr_p1;
  logic [PW-1:0]   last_p1;
  logic            vld_p1;
  logic [AW-1:0]   rd_p1;
  logic [DW-1:0]   wdata_p1;

  logic [NREQ-1:0] gnt_oh_p0;
  logic [PW-1:0]   gnt_idx_p0;
  logic            vld_p0;
  logic [AW-1:0]   rd_p0;
  logic [DW-1:0]   wdata_p0;

  // Stage p0: combinational round-robin scan starting at ptr. The scan wraps
  // by subtraction since ptr is always < NREQ. Only req_valid and hold feed
  // the grant; rd/wdata never do.
  always_comb begin
    int idx;
    gnt_oh_p0  = '0;
    gnt_idx_p0 = '0;
    vld_p0     = 1'b0;
    idx        = 0;
    if (!hold) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr_p1) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!vld_p0 && req_valid[idx]) begin
          vld_p0         = 1'b1;
          gnt_idx_p0     = PW'(idx);
          gnt_oh_p0[idx] = 1'b1;
        end
      end
    end
  end

  // Winner's payload; a one-hot AND-OR mux so no index arithmetic on buses.
  always_comb begin
    rd_p0    = '0;
    wdata_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh_p0[i]) begin
        rd_p0    = req_rd[i*AW +: AW];
        wdata_p0 = req_wdata[i*DW +: DW];
      end
    end
  end

  // Grants are masked while reset is asserted so no requester sees a
  // handshake that the (held-in-reset) output stage would drop.
  assign req_ready = rst_n ? gnt_oh_p0 : '0;

  // Stage p1: output register. A grant always implies a transfer because
  // ready is only raised on a valid requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      rd_p1    <= '0;
      wdata_p1 <= '0;
      last_p1  <= '0;
      ptr_p1   <= '0;
    end else if (vld_p0) begin
      vld_p1   <= rd_writes(rd_p0);
      rd_p1    <= rd_p0;
      wdata_p1 <= wdata_p0;
      last_p1  <= gnt_idx_p0;
      ptr_p1   <= rr_next(gnt_idx_p0);
    end else begin
      vld_p1   <= 1'b0;
    end
  end

  assign rf_we      = vld_p1;
  assign rf_rd      = rd_p1;
  assign rf_wdata   = wdata_p1;
  assign pend_valid = vld_p1;
  assign pend_rd    = rd_p1;
  assign last_gnt   = last_p1;

endmodule
